// File: rtl/alu_issue_stage.sv
// ID/EX issue stage feeding the execute ALU: registers decoded fields, decodes the ALU control
// code, resolves operand forwarding (optional macro ALU_ISSUE_FWD_EN) and holds multi-cycle muls.
module alu_issue_stage #(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        ALUSrc_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [6:0]  funct7_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] RS1data_i,
  input  logic [31:0] RS2data_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  RS1addr_i,
  input  logic [4:0]  RS2addr_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        EXMEM_RegWrite_i,
  input  logic        MEMWB_RegWrite_i,
  input  logic [4:0]  EXMEM_RDaddr_i,
  input  logic [4:0]  MEMWB_RDaddr_i,
  input  logic [31:0] EXMEM_data_i,
  input  logic [31:0] MEMWB_data_i,
  output logic [2:0]  ALUCtl_o,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] RS2fwd_o,
  output logic [4:0]  RDaddr_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        valid_o,
  output logic        busy_o
);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_XOR = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SLL = 3'b011,
    ALU_MUL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SRA = 3'b111
  } alu_ctl_e;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic        memread;
    logic        memwrite;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] rs1data;
    logic [31:0] rs2data;
    logic [31:0] imm;
    logic [4:0]  rs1addr;
    logic [4:0]  rs2addr;
    logic [4:0]  rdaddr;
  } stage_t;

  localparam logic [3:0] HOLD_INIT = 4'(MUL_CYCLES - 1);

  stage_t      stage_q, stage_d;
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] fwd_rs1, fwd_rs2;
  logic        busy;
  logic        load_is_mul;

  function automatic alu_ctl_e decode_ctl(input logic [1:0] aluop,
                                          input logic [6:0] f7,
                                          input logic [2:0] f3);
    decode_ctl = ALU_ADD;
    case (aluop)
      2'b01: decode_ctl = ALU_SUB;
      2'b10: begin
        case ({f7, f3})
          10'b0000000_111: decode_ctl = ALU_AND;
          10'b0000000_100: decode_ctl = ALU_XOR;
          10'b0000000_001: decode_ctl = ALU_SLL;
          10'b0000001_000: decode_ctl = ALU_MUL;
          10'b0100000_000: decode_ctl = ALU_SUB;
          default:         decode_ctl = ALU_ADD;
        endcase
      end
      2'b11: begin
        if (f3 == 3'b101 && f7 == 7'b0100000) decode_ctl = ALU_SRA;
      end
      default: decode_ctl = ALU_ADD;
    endcase
  endfunction

`ifdef ALU_ISSUE_FWD_EN
  // EX/MEM is the younger producer, so it beats MEM/WB; x0 is hard-wired and never forwards.
  function automatic logic [31:0] fwd_sel(input logic [4:0] addr, input logic [31:0] reg_data);
    if (addr != 5'd0 && EXMEM_RegWrite_i && EXMEM_RDaddr_i == addr) fwd_sel = EXMEM_data_i;
    else if (addr != 5'd0 && MEMWB_RegWrite_i && MEMWB_RDaddr_i == addr) fwd_sel = MEMWB_data_i;
    else fwd_sel = reg_data;
  endfunction

  assign fwd_rs1 = fwd_sel(stage_q.rs1addr, stage_q.rs1data);
  assign fwd_rs2 = fwd_sel(stage_q.rs2addr, stage_q.rs2data);
`else
  logic unused_fwd;
  assign unused_fwd = ^{EXMEM_RegWrite_i, MEMWB_RegWrite_i, EXMEM_RDaddr_i, MEMWB_RDaddr_i,
                        EXMEM_data_i, MEMWB_data_i, stage_q.rs1addr, stage_q.rs2addr};
  assign fwd_rs1 = stage_q.rs1data;
  assign fwd_rs2 = stage_q.rs2data;
`endif

  assign load_is_mul = valid_i && (decode_ctl(ALUOp_i, funct7_i, funct3_i) == ALU_MUL);
  assign busy        = (state_q == S_HOLD);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    stage_d = stage_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (busy) begin
      // Capture forwarded operands so the mul survives its producers leaving the pipe.
      stage_d.rs1data = fwd_rs1;
      stage_d.rs2data = fwd_rs2;
      cnt_d           = cnt_q - 4'd1;
      if (cnt_q == 4'd1) state_d = S_IDLE;
    end else if (flush_i) begin
      stage_d.valid    = 1'b0;
      stage_d.regwrite = 1'b0;
      stage_d.memread  = 1'b0;
      stage_d.memwrite = 1'b0;
      stage_d.memtoreg = 1'b0;
    end else if (!stall_i) begin
      stage_d.valid    = valid_i;
      stage_d.regwrite = RegWrite_i;
      stage_d.memtoreg = MemtoReg_i;
      stage_d.memread  = MemRead_i;
      stage_d.memwrite = MemWrite_i;
      stage_d.alusrc   = ALUSrc_i;
      stage_d.aluop    = ALUOp_i;
      stage_d.funct7   = funct7_i;
      stage_d.funct3   = funct3_i;
      stage_d.rs1data  = RS1data_i;
      stage_d.rs2data  = RS2data_i;
      stage_d.imm      = imm_i;
      stage_d.rs1addr  = RS1addr_i;
      stage_d.rs2addr  = RS2addr_i;
      stage_d.rdaddr   = RDaddr_i;
      if (load_is_mul && MUL_CYCLES > 1) begin
        state_d = S_HOLD;
        cnt_d   = HOLD_INIT;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stage_q <= '0;
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      stage_q <= stage_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ALUCtl_o   = decode_ctl(stage_q.aluop, stage_q.funct7, stage_q.funct3);
  assign a_o        = fwd_rs1;
  assign b_o        = stage_q.alusrc ? stage_q.imm : fwd_rs2;
  assign RS2fwd_o   = fwd_rs2;
  assign RDaddr_o   = stage_q.rdaddr;
  // While holding, downstream sees bubbles; the true controls reappear on the release cycle.
  assign RegWrite_o = stage_q.regwrite & ~busy;
  assign MemRead_o  = stage_q.memread & ~busy;
  assign MemWrite_o = stage_q.memwrite & ~busy;
  assign MemtoReg_o = stage_q.memtoreg;
  assign valid_o    = stage_q.valid & ~busy;
  assign busy_o     = busy;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized traffic against
// a behavioural model; forwarding expectations follow the ALU_ISSUE_FWD_EN macro.
module tb_alu_issue_stage;

  localparam int unsigned MUL_CYCLES = 3;
`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk, rst_n;
  logic stall_i, flush_i, valid_i;
  logic regwrite_i, memtoreg_i, memread_i, memwrite_i, alusrc_i;
  logic [1:0]  aluop_i;
  logic [6:0]  funct7_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1data_i, rs2data_i, imm_i;
  logic [4:0]  rs1addr_i, rs2addr_i, rdaddr_i;
  logic        exmem_we, memwb_we;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_data, memwb_data;

  logic [2:0]  alu_ctl_o;
  logic [31:0] a_o, b_o, rs2fwd_o;
  logic [4:0]  rdaddr_o;
  logic        regwrite_o, memtoreg_o, memread_o, memwrite_o, valid_o, busy_o;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk_i(clk), .rst_i(rst_n), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .RegWrite_i(regwrite_i), .MemtoReg_i(memtoreg_i), .MemRead_i(memread_i),
    .MemWrite_i(memwrite_i), .ALUSrc_i(alusrc_i), .ALUOp_i(aluop_i),
    .funct7_i(funct7_i), .funct3_i(funct3_i),
    .RS1data_i(rs1data_i), .RS2data_i(rs2data_i), .imm_i(imm_i),
    .RS1addr_i(rs1addr_i), .RS2addr_i(rs2addr_i), .RDaddr_i(rdaddr_i),
    .EXMEM_RegWrite_i(exmem_we), .MEMWB_RegWrite_i(memwb_we),
    .EXMEM_RDaddr_i(exmem_rd), .MEMWB_RDaddr_i(memwb_rd),
    .EXMEM_data_i(exmem_data), .MEMWB_data_i(memwb_data),
    .ALUCtl_o(alu_ctl_o), .a_o(a_o), .b_o(b_o), .RS2fwd_o(rs2fwd_o), .RDaddr_o(rdaddr_o),
    .RegWrite_o(regwrite_o), .MemtoReg_o(memtoreg_o), .MemRead_o(memread_o),
    .MemWrite_o(memwrite_o), .valid_o(valid_o), .busy_o(busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: the latched instruction plus a count of remaining busy cycles.
  logic        m_valid, m_rw, m_mtr, m_mr, m_mw, m_src;
  logic [1:0]  m_op;
  logic [6:0]  m_f7;
  logic [2:0]  m_f3;
  logic [31:0] m_d1, m_d2, m_imm;
  logic [4:0]  m_a1, m_a2, m_rd;
  int          m_left;

  task automatic m_reset();
    {m_valid, m_rw, m_mtr, m_mr, m_mw, m_src} = '0;
    m_op = '0; m_f7 = '0; m_f3 = '0;
    m_d1 = '0; m_d2 = '0; m_imm = '0;
    m_a1 = '0; m_a2 = '0; m_rd = '0;
    m_left = 0;
  endtask

  function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] regv);
    if (FWD && a != 0 && exmem_we && exmem_rd == a) return exmem_data;
    if (FWD && a != 0 && memwb_we && memwb_rd == a) return memwb_data;
    return regv;
  endfunction

  function automatic logic [2:0] m_ctl();
    if (m_op == 2'd1) return 3'd6;
    if (m_op == 2'd2) begin
      if (m_f7 == 7'h00 && m_f3 == 3'd7) return 3'd0;
      if (m_f7 == 7'h00 && m_f3 == 3'd4) return 3'd1;
      if (m_f7 == 7'h00 && m_f3 == 3'd1) return 3'd3;
      if (m_f7 == 7'h01 && m_f3 == 3'd0) return 3'd5;
      if (m_f7 == 7'h20 && m_f3 == 3'd0) return 3'd6;
    end
    if (m_op == 2'd3 && m_f3 == 3'd5 && m_f7 == 7'h20) return 3'd7;
    return 3'd2;
  endfunction

  task automatic model_edge();
    logic [31:0] n1, n2;
    if (!rst_n) begin
      m_reset();
    end else if (m_left > 0) begin
      n1 = m_fwd(m_a1, m_d1);
      n2 = m_fwd(m_a2, m_d2);
      m_d1 = n1;
      m_d2 = n2;
      m_left--;
    end else if (flush_i) begin
      {m_valid, m_rw, m_mr, m_mw, m_mtr} = '0;
    end else if (!stall_i) begin
      m_valid = valid_i; m_rw = regwrite_i; m_mtr = memtoreg_i; m_mr = memread_i;
      m_mw = memwrite_i; m_src = alusrc_i; m_op = aluop_i; m_f7 = funct7_i; m_f3 = funct3_i;
      m_d1 = rs1data_i; m_d2 = rs2data_i; m_imm = imm_i;
      m_a1 = rs1addr_i; m_a2 = rs2addr_i; m_rd = rdaddr_i;
      if (valid_i && aluop_i == 2'd2 && funct7_i == 7'h01 && funct3_i == 3'd0 && MUL_CYCLES > 1)
        m_left = MUL_CYCLES - 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic busy;
    busy = (m_left > 0);
    check("busy",    32'(busy_o),     32'(busy));
    check("valid",   32'(valid_o),    32'(m_valid && !busy));
    check("regwr",   32'(regwrite_o), 32'(m_rw && !busy));
    check("memrd",   32'(memread_o),  32'(m_mr && !busy));
    check("memwr",   32'(memwrite_o), 32'(m_mw && !busy));
    check("memtoreg",32'(memtoreg_o), 32'(m_mtr));
    check("aluctl",  32'(alu_ctl_o),  32'(m_ctl()));
    check("a",       a_o,             m_fwd(m_a1, m_d1));
    check("b",       b_o,             m_src ? m_imm : m_fwd(m_a2, m_d2));
    check("rs2fwd",  rs2fwd_o,        m_fwd(m_a2, m_d2));
    check("rd",      32'(rdaddr_o),   32'(m_rd));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #3;
    check_all();
  endtask

  task automatic idle_inputs();
    {stall_i, flush_i, valid_i, regwrite_i, memtoreg_i, memread_i, memwrite_i, alusrc_i} = '0;
    aluop_i = '0; funct7_i = '0; funct3_i = '0;
    rs1data_i = '0; rs2data_i = '0; imm_i = '0;
    rs1addr_i = '0; rs2addr_i = '0; rdaddr_i = '0;
    exmem_we = 1'b0; memwb_we = 1'b0; exmem_rd = '0; memwb_rd = '0;
    exmem_data = '0; memwb_data = '0;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [4:0] a1, input logic [4:0] a2);
    valid_i = 1'b1; regwrite_i = 1'b1; memtoreg_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0;
    alusrc_i = 1'b0; aluop_i = op; funct7_i = f7; funct3_i = f3;
    rs1data_i = d1; rs2data_i = d2; imm_i = '0;
    rs1addr_i = a1; rs2addr_i = a2; rdaddr_i = 5'd3;
  endtask

  initial begin
    idle_inputs();
    m_reset();
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    #1;
    check("rst_valid", 32'(valid_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_ctl", 32'(alu_ctl_o), 32'd2);
    check("rst_a", a_o, 0);
    check("rst_b", b_o, 0);
    check("rst_rs2", rs2fwd_o, 0);
    check("rst_regwr", 32'(regwrite_o), 0);
    check_all();

    // R-type sub
    set_instr(2'd2, 7'h20, 3'd0, 32'd9, 32'd4, 5'd1, 5'd2);
    step();
    check("sub_ctl", 32'(alu_ctl_o), 32'd6);
    check("sub_a", a_o, 32'd9);
    check("sub_b", b_o, 32'd4);
    check("sub_valid", 32'(valid_o), 1);

    // Forwarding priority on rs1 = x5
    set_instr(2'd2, 7'h00, 3'd0, 32'h55, 32'h1, 5'd5, 5'd6);
    step();
    exmem_we = 1'b1; exmem_rd = 5'd5; exmem_data = 32'h11;
    memwb_we = 1'b1; memwb_rd = 5'd5; memwb_data = 32'h22;
    #1 check("fwd_exmem", a_o, FWD ? 32'h11 : 32'h55);
    exmem_we = 1'b0;
    #1 check("fwd_memwb", a_o, FWD ? 32'h22 : 32'h55);
    set_instr(2'd2, 7'h00, 3'd0, 32'h66, 32'h1, 5'd0, 5'd6);
    step();
    exmem_we = 1'b1; exmem_rd = 5'd0; memwb_we = 1'b1; memwb_rd = 5'd0;
    #1 check("fwd_x0", a_o, 32'h66);
    exmem_we = 1'b0; memwb_we = 1'b0;

    // Mul hold with flush pulsed while busy
    set_instr(2'd2, 7'h01, 3'd0, 32'd3, 32'd5, 5'd6, 5'd7);
    step();
    set_instr(2'd3, 7'h00, 3'd0, 32'd1, 32'd1, 5'd1, 5'd1);
    for (int k = 0; k < int'(MUL_CYCLES) - 1; k++) begin
      check("mul_busy", 32'(busy_o), 1);
      check("mul_valid_low", 32'(valid_o), 0);
      flush_i = (k == 0);
      step();
    end
    flush_i = 1'b0;
    check("mul_done_busy", 32'(busy_o), 0);
    check("mul_done_valid", 32'(valid_o), 1);
    check("mul_done_ctl", 32'(alu_ctl_o), 32'd5);
    idle_inputs();

    // Operand drain: rs1 forwarded once, producer then becomes a bubble
    set_instr(2'd2, 7'h01, 3'd0, 32'h100, 32'd2, 5'd9, 5'd10);
    step();
    idle_inputs();
    exmem_we = 1'b1; exmem_rd = 5'd9; exmem_data = 32'h7;
    #1 check("drain_entry", a_o, FWD ? 32'h7 : 32'h100);
    step();
    exmem_we = 1'b0;
    #1 check("drain_hold", a_o, FWD ? 32'h7 : 32'h100);
    step();
    check("drain_exit", a_o, FWD ? 32'h7 : 32'h100);
    check("drain_valid", 32'(valid_o), 1);

    // addi with negative immediate, then flush
    set_instr(2'd3, 7'h7f, 3'd0, 32'd1, 32'd2, 5'd1, 5'd2);
    alusrc_i = 1'b1; imm_i = 32'hFFFF_FFFD;
    step();
    check("addi_b", b_o, 32'hFFFF_FFFD);
    check("addi_ctl", 32'(alu_ctl_o), 32'd2);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_valid", 32'(valid_o), 0);
    check("flush_regwr", 32'(regwrite_o), 0);
    check("flush_memwr", 32'(memwrite_o), 0);

    // Store, then stall with changing inputs
    set_instr(2'd0, 7'h00, 3'd2, 32'h1000, 32'hABCD, 5'd3, 5'd4);
    regwrite_i = 1'b0; memwrite_i = 1'b1; alusrc_i = 1'b1; imm_i = 32'h10; rdaddr_i = 5'd0;
    step();
    stall_i = 1'b1;
    set_instr(2'd2, 7'h00, 3'd4, 32'h5, 32'h6, 5'd8, 5'd9);
    step();
    step();
    check("stall_a", a_o, 32'h1000);
    check("stall_b", b_o, 32'h10);
    check("stall_rs2", rs2fwd_o, 32'hABCD);
    check("stall_memwr", 32'(memwrite_o), 1);
    check("stall_regwr", 32'(regwrite_o), 0);
    check("stall_ctl", 32'(alu_ctl_o), 32'd2);
    check("stall_valid", 32'(valid_o), 1);
    stall_i = 1'b0;

    // Asynchronous reset mid-hold
    set_instr(2'd2, 7'h01, 3'd0, 32'd3, 32'd5, 5'd6, 5'd7);
    step();
    check("pre_rst_busy", 32'(busy_o), 1);
    #1 rst_n = 1'b0;
    #1;
    m_reset();
    check("arst_busy", 32'(busy_o), 0);
    check("arst_valid", 32'(valid_o), 0);
    check("arst_ctl", 32'(alu_ctl_o), 32'd2);
    #2 rst_n = 1'b1;
    set_instr(2'd2, 7'h00, 3'd4, 32'h3, 32'h5, 5'd1, 5'd2);
    step();
    check("post_rst_ctl", 32'(alu_ctl_o), 32'd1);
    check("post_rst_valid", 32'(valid_o), 1);
    check("post_rst_busy", 32'(busy_o), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      valid_i    = ($urandom_range(0, 3) != 0);
      regwrite_i = 1'($urandom); memtoreg_i = 1'($urandom);
      memread_i  = 1'($urandom); memwrite_i = 1'($urandom); alusrc_i = 1'($urandom);
      aluop_i    = 2'($urandom);
      funct3_i   = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       funct7_i = 7'h00;
        1:       funct7_i = 7'h01;
        2:       funct7_i = 7'h20;
        default: funct7_i = 7'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) begin
        aluop_i = 2'd2; funct7_i = 7'h01; funct3_i = 3'd0;
      end
      rs1data_i = $urandom; rs2data_i = $urandom; imm_i = $urandom;
      rs1addr_i = 5'($urandom_range(0, 7)); rs2addr_i = 5'($urandom_range(0, 7));
      rdaddr_i  = 5'($urandom);
      stall_i   = ($urandom_range(0, 7) == 0);
      flush_i   = ($urandom_range(0, 7) == 0);
      exmem_we  = 1'($urandom); memwb_we = 1'($urandom);
      exmem_rd  = 5'($urandom_range(0, 7)); memwb_rd = 5'($urandom_range(0, 7));
      exmem_data = $urandom; memwb_data = $urandom;
      #1 check_all();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
